vid_out_lock_ctrl: RTL and testbench
====================================

// Module: vid_out_lock_ctrl
// PURPOSE
//  Start-up and recovery sequencer for the AXI4-Stream-to-video-out bridge. Drives the
//  bridge's rst and the timing generator's enable, then waits for the bridge's locked flag.
//  On loss of lock it resets the bridge and retries. It counts write errors and underflows,
//  and reports status to the PS register block. Lives in the aclk domain beside the bridge.
// PARAMETERS
//  RST_CYCLES   16       cycles core_rst is held high per reset pulse (>=1)
//  LOCK_TIMEOUT 1048575  cycles allowed in WAIT_LOCK before declaring FAULT (>=1)
//  TO_W         20       timeout counter width; must hold LOCK_TIMEOUT
//  MAX_RETRY    3        lock-loss retries before FAULT (0 = first loss faults)
//  CNT_W        8        width of the saturating event counters
// PORTS
//  aclk           in   1      system clock
//  aresetn        in   1      asynchronous active-low reset
//  enable         in   1      level; 1 = bring video output up, 0 = shut down
//  clear_fault    in   1      1-cycle pulse; leaves FAULT
//  locked         in   1      bridge lock flag
//  wr_error       in   1      bridge FIFO write error
//  empty          in   1      bridge FIFO empty
//  core_rst       out  1      active-high reset to the bridge rst input
//  vtg_en         out  1      timing generator enable
//  state          out  3      IDLE=0 RST=1 WAIT_LOCK=2 RUN=3 FAULT=4
//  fault          out  1      1 while in FAULT
//  timeout_flag   out  1      sticky; set on WAIT_LOCK timeout
//  lock_lost_cnt  out  CNT_W  lock losses while in RUN, saturating
//  wr_err_cnt     out  CNT_W  rising edges of wr_error while in RUN, saturating
//  underflow_cnt  out  CNT_W  rising edges of empty while in RUN, saturating
//  irq            out  1      interrupt, see CONFIGURATION
// BEHAVIOUR
//  - Reset (aresetn=0): state=IDLE, core_rst=1, vtg_en=0, all counters, retry count,
//    timeout_flag and irq = 0; sync flops = 0. Asserting aresetn mid-operation aborts at once.
//  - locked, wr_error and empty pass through 2-flop synchronizers (_s). Edge detect uses a
//    third flop. An input change reaches the FSM decision 2 edges later, and the state
//    output changes on the 3rd edge.
//  - Outputs are registered and decoded from state: core_rst=1 in IDLE, RST and FAULT;
//    vtg_en=1 in WAIT_LOCK and RUN only.
//  - enable=0 in any state except FAULT -> IDLE on the next edge. This has top priority.
//  - IDLE: retry count is cleared. enable=1 -> RST and cnt loads RST_CYCLES-1.
//  - RST: cnt decrements each cycle. cnt==0 -> WAIT_LOCK and cnt loads LOCK_TIMEOUT-1.
//    core_rst is high for exactly RST_CYCLES cycles.
//  - WAIT_LOCK: locked_s=1 -> RUN. Otherwise cnt==0 -> FAULT and timeout_flag is set.
//    If both happen in the same cycle, locked wins.
//  - RUN: on a falling edge of locked_s, lock_lost_cnt++. Then, if retry<MAX_RETRY,
//    retry++ and go to RST. Otherwise go to FAULT.
//  - RUN: a wr_error_s rising edge increments wr_err_cnt; an empty_s rising edge increments
//    underflow_cnt. Both may increment in the same cycle. Events outside RUN are ignored.
//  - Counters saturate at 2^CNT_W-1 and never wrap. They clear only on aresetn or on
//    clear_fault.
//  - FAULT: holds regardless of enable. clear_fault=1 -> IDLE, and clears timeout_flag,
//    all counters and irq. clear_fault outside FAULT is ignored.
// CONFIGURATION
//  - VOC_IRQ_EN defined: irq is a sticky flag. It sets on entry to FAULT and on any
//    lock_lost_cnt increment, and clears on clear_fault in FAULT or on aresetn.
//  - VOC_IRQ_EN undefined: irq is tied to 0 and no irq flop exists. All else is identical.
// TESTING  (RST_CYCLES=4, LOCK_TIMEOUT=16, MAX_RETRY=2, CNT_W=4)
//  1 Release aresetn, enable=1 at cycle 0 -> state=1; core_rst high 4 cycles; then state=2,
//    vtg_en=1. Raise locked -> state=3 on the 3rd edge.
//  2 enable=1, locked held 0 -> state=4 exactly 16 cycles after entering WAIT_LOCK;
//    timeout_flag=1, fault=1, core_rst=1.
//  3 In RUN, drop locked 3 times, re-locking each time -> two RST/WAIT_LOCK cycles, then
//    FAULT on the 3rd loss; lock_lost_cnt=3.
//  4 In RUN, 20 wr_error pulses and one empty pulse in the same cycle as one of them ->
//    wr_err_cnt=15 (saturated), underflow_cnt=1.
//  5 enable=0 during RST with cnt=2, and separately during FAULT -> IDLE next edge from RST;
//    FAULT holds until clear_fault, then IDLE with counters=0.
//  6 With VOC_IRQ_EN: a lock loss sets irq=1 and irq persists until clear_fault in FAULT.
//    Without VOC_IRQ_EN: irq stays 0 throughout test 3.

Source files
------------

// File: rtl/vid_out_lock_ctrl.sv
// vid_out_lock_ctrl: start-up and recovery sequencer for the AXI4-Stream-to-video-out
// bridge. Pulses the bridge reset, enables the timing generator, waits for lock,
// retries on lock loss and counts bridge error events while running.
//
// Optional feature macro: VOC_IRQ_EN (sticky irq flag). Undefined: irq tied to 0.
//
// Ports:
//   aclk, aresetn          clock, async active-low reset
//   enable                 level request to bring video up (0 = shut down)
//   clear_fault            pulse, leaves FAULT and clears status
//   locked/wr_error/empty  bridge status, asynchronous to the FSM (synchronized here)
//   core_rst, vtg_en       bridge reset / timing generator enable
//   state, fault           FSM state (IDLE=0 RST=1 WAIT_LOCK=2 RUN=3 FAULT=4), FAULT flag
//   timeout_flag           sticky lock-timeout flag
//   lock_lost_cnt, wr_err_cnt, underflow_cnt  saturating event counters
//   irq                    interrupt flag
module vid_out_lock_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 1048575,
  parameter int unsigned TO_W         = 20,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic             clear_fault,
  input  logic             locked,
  input  logic             wr_error,
  input  logic             empty,
  output logic             core_rst,
  output logic             vtg_en,
  output logic [2:0]       state,
  output logic             fault,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] lock_lost_cnt,
  output logic [CNT_W-1:0] wr_err_cnt,
  output logic [CNT_W-1:0] underflow_cnt,
  output logic             irq
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RST       = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t             state_q, state_nxt;
  logic [TO_W-1:0]    cnt_q, cnt_nxt;
  logic [RETRY_W-1:0] retry_q;
  logic               core_rst_nxt, vtg_en_nxt, fault_nxt;

  // [0] metastability flop, [1] synchronized value, [2] previous value for edge detect
  logic [2:0] lock_sr, werr_sr, empty_sr;
  logic       locked_s, lock_fall, werr_rise, empty_rise, fault_clr;

  assign locked_s   = lock_sr[1];
  assign lock_fall  = lock_sr[2] & ~lock_sr[1];
  assign werr_rise  = werr_sr[1] & ~werr_sr[2];
  assign empty_rise = empty_sr[1] & ~empty_sr[2];
  assign fault_clr  = (state_q == S_FAULT) && clear_fault;
  assign state      = state_q;

  // Input synchronizers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lock_sr  <= '0;
      werr_sr  <= '0;
      empty_sr <= '0;
    end else begin
      lock_sr  <= {lock_sr[1:0], locked};
      werr_sr  <= {werr_sr[1:0], wr_error};
      empty_sr <= {empty_sr[1:0], empty};
    end
  end

  // State register, shared cycle counter and registered state-decoded outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      core_rst <= 1'b1;
      vtg_en   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      core_rst <= core_rst_nxt;
      vtg_en   <= vtg_en_nxt;
      fault    <= fault_nxt;
    end
  end

  // Next-state logic; enable=0 overrides everything except FAULT
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_nxt = S_RST;
          cnt_nxt   = TO_W'(RST_CYCLES - 1);
        end
      end
      S_RST: begin
        if (cnt_q == '0) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = TO_W'(LOCK_TIMEOUT - 1);
        end else begin
          cnt_nxt = cnt_q - TO_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = S_RUN;
        end else if (cnt_q == '0) begin
          state_nxt = S_FAULT;
        end else begin
          cnt_nxt = cnt_q - TO_W'(1);
        end
      end
      S_RUN: begin
        if (lock_fall) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            state_nxt = S_RST;
            cnt_nxt   = TO_W'(RST_CYCLES - 1);
          end else begin
            state_nxt = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        if (clear_fault) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!enable && (state_q != S_FAULT)) state_nxt = S_IDLE;
  end

  // Output decode from the next state so registered outputs line up with state
  always_comb begin
    core_rst_nxt = 1'b1;
    vtg_en_nxt   = 1'b0;
    fault_nxt    = 1'b0;
    unique case (state_nxt)
      S_WAIT_LOCK, S_RUN: begin
        core_rst_nxt = 1'b0;
        vtg_en_nxt   = 1'b1;
      end
      S_FAULT: fault_nxt = 1'b1;
      default: ;
    endcase
  end

  // Retry count, timeout flag and saturating event counters
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      retry_q       <= '0;
      timeout_flag  <= 1'b0;
      lock_lost_cnt <= '0;
      wr_err_cnt    <= '0;
      underflow_cnt <= '0;
    end else begin
      if (state_q == S_IDLE) begin
        retry_q <= '0;
      end else if ((state_q == S_RUN) && (state_nxt == S_RST)) begin
        retry_q <= retry_q + RETRY_W'(1);
      end

      if (fault_clr) begin
        timeout_flag  <= 1'b0;
        lock_lost_cnt <= '0;
        wr_err_cnt    <= '0;
        underflow_cnt <= '0;
      end else begin
        if ((state_q == S_WAIT_LOCK) && (state_nxt == S_FAULT)) timeout_flag <= 1'b1;
        if (state_q == S_RUN) begin
          if (lock_fall && (lock_lost_cnt != '1)) lock_lost_cnt <= lock_lost_cnt + CNT_W'(1);
          if (werr_rise && (wr_err_cnt != '1))    wr_err_cnt    <= wr_err_cnt + CNT_W'(1);
          if (empty_rise && (underflow_cnt != '1)) underflow_cnt <= underflow_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef VOC_IRQ_EN
  logic fault_entry, lost_inc;
  assign fault_entry = (state_nxt == S_FAULT) && (state_q != S_FAULT);
  assign lost_inc    = (state_q == S_RUN) && lock_fall && (lock_lost_cnt != '1);

  // Sticky interrupt: FAULT entry or lock-loss count, cleared with the fault
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      irq <= 1'b0;
    end else if (fault_clr) begin
      irq <= 1'b0;
    end else if (fault_entry || lost_inc) begin
      irq <= 1'b1;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_vid_out_lock_ctrl.sv
// Bench for vid_out_lock_ctrl: directed vector table, hand-written corner sequences and
// randomized stimulus checked every cycle against a behavioural model.
module tb_vid_out_lock_ctrl;

  localparam int RC = 4;
  localparam int LT = 16;
  localparam int MR = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          aclk = 1'b0;
  logic          aresetn, enable, clear_fault, locked, wr_error, empty;
  logic          core_rst, vtg_en, fault, timeout_flag, irq;
  logic [2:0]    state;
  logic [CW-1:0] lock_lost_cnt, wr_err_cnt, underflow_cnt;

  int tests = 0;
  int fails = 0;

  vid_out_lock_ctrl #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .TO_W(8), .MAX_RETRY(MR), .CNT_W(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .clear_fault(clear_fault),
    .locked(locked), .wr_error(wr_error), .empty(empty),
    .core_rst(core_rst), .vtg_en(vtg_en), .state(state), .fault(fault),
    .timeout_flag(timeout_flag), .lock_lost_cnt(lock_lost_cnt), .wr_err_cnt(wr_err_cnt),
    .underflow_cnt(underflow_cnt), .irq(irq)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Behavioural model: state as a number, time spent in the current state, and input
  // histories (index 0 = newest sample, 1 = synchronized, 2 = previous synchronized).
  int m_state, m_age, m_retry, m_lost, m_wr, m_und;
  bit m_to, m_irq;
  bit [2:0] h_lk, h_we, h_em;

  task automatic model_reset();
    m_state = 0; m_age = 0; m_retry = 0; m_lost = 0; m_wr = 0; m_und = 0;
    m_to = 0; m_irq = 0; h_lk = '0; h_we = '0; h_em = '0;
  endtask

  task automatic model_tick(input bit en, input bit cf, input bit lk, input bit we,
                            input bit em);
    int nxt;
    bit lfall, wrise, erise;
    lfall = h_lk[2] && !h_lk[1];
    wrise = h_we[1] && !h_we[2];
    erise = h_em[1] && !h_em[2];
    nxt = m_state;
    case (m_state)
      0: begin
        m_retry = 0;
        if (en) begin nxt = 1; m_age = 0; end
      end
      1: if (m_age == RC - 1) begin nxt = 2; m_age = 0; end else m_age++;
      2: if (h_lk[1]) nxt = 3; else if (m_age == LT - 1) nxt = 4; else m_age++;
      3: if (lfall) begin
           if (m_retry < MR) begin nxt = 1; m_age = 0; m_retry++; end
           else nxt = 4;
         end
      default: if (cf) nxt = 0;
    endcase
    if (!en && m_state != 4) nxt = 0;
    if (m_state == 2 && nxt == 4) m_to = 1;
    if (nxt == 4 && m_state != 4) m_irq = 1;
    if (m_state == 3) begin
      if (lfall && m_lost < CMAX) begin m_lost++; m_irq = 1; end
      if (wrise && m_wr < CMAX) m_wr++;
      if (erise && m_und < CMAX) m_und++;
    end
    if (m_state == 4 && cf) begin
      m_lost = 0; m_wr = 0; m_und = 0; m_to = 0; m_irq = 0;
    end
    m_state = nxt;
    h_lk = {h_lk[1:0], lk};
    h_we = {h_we[1:0], we};
    h_em = {h_em[1:0], em};
  endtask

  function automatic bit irq_exp(input bit v);
`ifdef VOC_IRQ_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model.state", int'(state), m_state);
    check("model.core_rst", int'(core_rst), (m_state == 0 || m_state == 1 || m_state == 4) ? 1 : 0);
    check("model.vtg_en", int'(vtg_en), (m_state == 2 || m_state == 3) ? 1 : 0);
    check("model.fault", int'(fault), (m_state == 4) ? 1 : 0);
    check("model.timeout_flag", int'(timeout_flag), int'(m_to));
    check("model.lock_lost_cnt", int'(lock_lost_cnt), m_lost);
    check("model.wr_err_cnt", int'(wr_err_cnt), m_wr);
    check("model.underflow_cnt", int'(underflow_cnt), m_und);
    check("model.irq", int'(irq), int'(irq_exp(m_irq)));
  endtask

  // One clock: sample driven inputs, advance the model, compare after the edge
  task automatic step();
    bit en, cf, lk, we, em;
    en = enable; cf = clear_fault; lk = locked; we = wr_error; em = empty;
    @(posedge aclk);
    #1;
    model_tick(en, cf, lk, we, em);
    check_model();
  endtask

  typedef struct {
    bit en; bit cf; bit lk; int n;
    int st; int crst; int vtg; int lost; int irqv;
  } vec_t;
  vec_t vt[17];

  initial begin
    aresetn = 1'b0; enable = 1'b0; clear_fault = 1'b0;
    locked = 1'b0; wr_error = 1'b0; empty = 1'b0;
    model_reset();

    // Bring-up, three lock losses with re-lock, FAULT hold and clear
    vt[0]  = '{1, 0, 0, 1, 1, 1, 0, 0, 0};
    vt[1]  = '{1, 0, 0, 3, 1, 1, 0, 0, 0};
    vt[2]  = '{1, 0, 0, 1, 2, 0, 1, 0, 0};
    vt[3]  = '{1, 0, 1, 2, 2, 0, 1, 0, 0};
    vt[4]  = '{1, 0, 1, 1, 3, 0, 1, 0, 0};
    vt[5]  = '{1, 0, 1, 5, 3, 0, 1, 0, 0};
    vt[6]  = '{1, 0, 0, 2, 3, 0, 1, 0, 0};
    vt[7]  = '{1, 0, 0, 1, 1, 1, 0, 1, 1};
    vt[8]  = '{1, 0, 0, 4, 2, 0, 1, 1, 1};
    vt[9]  = '{1, 0, 1, 3, 3, 0, 1, 1, 1};
    vt[10] = '{1, 0, 0, 3, 1, 1, 0, 2, 1};
    vt[11] = '{1, 0, 0, 4, 2, 0, 1, 2, 1};
    vt[12] = '{1, 0, 1, 3, 3, 0, 1, 2, 1};
    vt[13] = '{1, 0, 0, 3, 4, 1, 0, 3, 1};
    vt[14] = '{0, 0, 0, 3, 4, 1, 0, 3, 1};
    vt[15] = '{0, 1, 0, 1, 0, 1, 0, 0, 0};
    vt[16] = '{0, 0, 0, 2, 0, 1, 0, 0, 0};

    repeat (3) @(posedge aclk);
    #1;
    check("reset.state", int'(state), 0);
    check("reset.core_rst", int'(core_rst), 1);
    check("reset.vtg_en", int'(vtg_en), 0);
    check("reset.irq", int'(irq), 0);
    aresetn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      enable = vt[i].en; clear_fault = vt[i].cf; locked = vt[i].lk;
      for (int k = 0; k < vt[i].n; k++) step();
      check($sformatf("vec%0d.state", i), int'(state), vt[i].st);
      check($sformatf("vec%0d.core_rst", i), int'(core_rst), vt[i].crst);
      check($sformatf("vec%0d.vtg_en", i), int'(vtg_en), vt[i].vtg);
      check($sformatf("vec%0d.lock_lost", i), int'(lock_lost_cnt), vt[i].lost);
      check($sformatf("vec%0d.irq", i), int'(irq), int'(irq_exp(vt[i].irqv[0])));
    end
    clear_fault = 1'b0;

    // Lock timeout: FAULT exactly LT cycles after entering WAIT_LOCK
    enable = 1'b1; locked = 1'b0;
    repeat (RC) step();
    step();
    check("to.enter_wait", int'(state), 2);
    repeat (LT - 1) step();
    check("to.still_wait", int'(state), 2);
    step();
    check("to.state", int'(state), 4);
    check("to.timeout_flag", int'(timeout_flag), 1);
    check("to.fault", int'(fault), 1);
    check("to.core_rst", int'(core_rst), 1);
    enable = 1'b0; clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    check("to.clear_state", int'(state), 0);
    check("to.clear_flag", int'(timeout_flag), 0);

    // Saturating write-error counter plus a coincident underflow event
    enable = 1'b1; locked = 1'b1;
    begin
      int budget = 40;
      while (state != 3'd3 && budget > 0) begin step(); budget--; end
      check("sat.reach_run", int'(state), 3);
    end
    for (int i = 0; i < 20; i++) begin
      wr_error = 1'b1; empty = (i == 5);
      step();
      wr_error = 1'b0; empty = 1'b0;
      step();
    end
    repeat (3) step();
    check("sat.wr_err_cnt", int'(wr_err_cnt), CMAX);
    check("sat.underflow_cnt", int'(underflow_cnt), 1);

    // enable dropped during RST with cnt=2
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    step();
    enable = 1'b0;
    step();
    check("rst_abort.state", int'(state), 0);
    check("rst_abort.core_rst", int'(core_rst), 1);

    // Randomized traffic with one asynchronous mid-run reset
    for (int c = 0; c < 4000; c++) begin
      enable      = ($urandom_range(0, 99) < 97);
      clear_fault = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 8) locked = ~locked;
      wr_error    = ($urandom_range(0, 99) < 20);
      empty       = ($urandom_range(0, 99) < 10);
      step();
      if (c == 2000) begin
        #3 aresetn = 1'b0;
        #1;
        check("async_rst.state", int'(state), 0);
        check("async_rst.core_rst", int'(core_rst), 1);
        check("async_rst.lock_lost", int'(lock_lost_cnt), 0);
        model_reset();
        @(posedge aclk);
        #1 aresetn = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
